fwd_ctrl_unit: RTL

//  Forwarding/hazard controller for the 32-bit 4-stage pipeline (ID->EX->MEM->WB).

---
 rtl/riscv_fwd_pkg.sv | 38 +++
 rtl/fwd_stage_reg.sv | 21 ++
 rtl/fwd_ctrl_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_fwd_pkg.sv
// Shared stage-shadow type, mux sel encodings and match helpers for the EX forwarding controller.
package riscv_fwd_pkg;

    localparam int unsigned RF_ADDR_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } stage_info_t;

    localparam stage_info_t STAGE_EMPTY = '0;

    // A stage produces src when it holds a real register write to a non-zero rd equal to src.
    function automatic logic stage_match(input stage_info_t st, input logic [RF_ADDR_W-1:0] src);
        return st.valid && st.reg_write && (st.rd != '0) && (st.rd == src);
    endfunction

    // The EX producer reaches MEM on the same edge the consumer reaches EX, so it wins over MEM.
    function automatic logic [1:0] fwd_sel(input logic                 use_src,
                                           input logic [RF_ADDR_W-1:0] src,
                                           input stage_info_t          ex,
                                           input stage_info_t          mem);
        if (use_src && stage_match(ex, src)) begin
            return FWD_EXMEM;
        end
        if (use_src && stage_match(mem, src)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline-stage register: sync reset, freeze on hold, clear to empty on bubble.
module fwd_stage_reg
    import riscv_fwd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= STAGE_EMPTY;
        end else if (!hold) begin
            q <= bubble ? STAGE_EMPTY : d;
        end
    end

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Forwarding and load-use hazard controller for the ID->EX->MEM->WB pipeline.
// Optional stall counter port enabled by defining FWD_PERF_CNT_EN.
module fwd_ctrl_unit
    import riscv_fwd_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = RF_ADDR_W
`ifdef FWD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_hold,
    input  logic                  id_flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_id,
    output logic                  ex_bubble
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_count
`endif
);

    stage_info_t          id_info;
    stage_info_t          ex_q;
    stage_info_t          mem_q;
    stage_info_t          wb_q;
    logic [RF_ADDR_W-1:0] rs1;
    logic [RF_ADDR_W-1:0] rs2;
    logic [1:0]           sel_a;
    logic [1:0]           sel_b;
    logic                 ex_inject;
    logic                 load_hit;

    assign rs1 = RF_ADDR_W'(id_rs1);
    assign rs2 = RF_ADDR_W'(id_rs2);

    always_comb begin
        id_info           = STAGE_EMPTY;
        id_info.valid     = 1'b1;
        id_info.rd        = RF_ADDR_W'(id_rd);
        id_info.reg_write = id_reg_write;
        id_info.mem_read  = id_mem_read;
    end

    // Load data in EX is not available until MEM, so a dependent instruction in ID waits one cycle.
    always_comb begin
        load_hit = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)
                   && ((id_use_rs1 && (ex_q.rd == rs1)) || (id_use_rs2 && (ex_q.rd == rs2)));
        stall_id = !pipe_hold && id_valid && !id_flush && load_hit;
    end

    assign ex_inject = stall_id || id_flush || !id_valid;

    assign sel_a = fwd_sel(id_use_rs1, rs1, ex_q, mem_q);
    assign sel_b = fwd_sel(id_use_rs2, rs2, ex_q, mem_q);

    fwd_stage_reg u_ex_stage (
        .clk    (clk),
        .reset  (reset),
        .hold   (pipe_hold),
        .bubble (ex_inject),
        .d      (id_info),
        .q      (ex_q)
    );

    fwd_stage_reg u_mem_stage (
        .clk    (clk),
        .reset  (reset),
        .hold   (pipe_hold),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    fwd_stage_reg u_wb_stage (
        .clk    (clk),
        .reset  (reset),
        .hold   (pipe_hold),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    // Sels travel with the instruction into EX; a bubble always reads the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
            ex_bubble <= 1'b0;
        end else if (!pipe_hold) begin
            if (ex_inject) begin
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
                ex_bubble <= 1'b1;
            end else begin
                fwd_a_sel <= sel_a;
                fwd_b_sel <= sel_b;
                ex_bubble <= 1'b0;
            end
        end
    end

    // Empty slots are fully cleared, so a retired bubble can never pose as a producer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (wb_q.valid || (wb_q == STAGE_EMPTY));
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_id && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule
